wb_stage_mc: RTL and testbench

- Parametrised multi-lane writeback stage; successor of the single-lane WB stage. Sits between MEM and the regfile/trace interface.
- Latches an NUM_CH-lane MEM bundle with stall/flush bubble semantics.
- Performs load-data alignment and extension per lane, and drives per-lane regfile writes.
- Serialises retired writes through a trace FIFO onto the single-write debug port, raising a stall request when the FIFO cannot accept a bundle.

---
 rtl/wb_stage_mc_if.sv | 26 ++
 rtl/wb_stage_mc.sv | 95 +++++++++
 tb/tb_wb_stage_mc.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_mc_if.sv
// wb_stage_mc_if: MEM->WB bundle in, regfile writes, stall request, overflow flag and trace debug port out
interface wb_stage_mc_if #(
  parameter int NUM_CH  = 2,
  parameter int STALL_W = 6
);
  logic                   flush;
  logic [STALL_W-1:0]     stall;
  logic [NUM_CH*77-1:0]   mem_to_wb_bus;
  logic [NUM_CH*38-1:0]   wb_to_rf_bus;
  logic                   stallreq_wb;
  logic                   dbg_overflow;
  logic [31:0]            debug_wb_pc;
  logic [3:0]             debug_wb_rf_wen;
  logic [4:0]             debug_wb_rf_wnum;
  logic [31:0]            debug_wb_rf_wdata;
  modport master (
    output flush, stall, mem_to_wb_bus,
    input  wb_to_rf_bus, stallreq_wb, dbg_overflow,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
  modport slave (
    input  flush, stall, mem_to_wb_bus,
    output wb_to_rf_bus, stallreq_wb, dbg_overflow,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_stage_mc.sv
// wb_stage_mc: multi-lane writeback stage (clk, rst, bus: bundle in, regfile writes/stallreq/overflow/trace out)
module wb_stage_mc #(
  parameter int NUM_CH    = 2,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 4,
  parameter int DBG_DEPTH = 8
) (
  input logic         clk,
  input logic         rst,
  wb_stage_mc_if.slave bus
);
  localparam int LW = 77;
  localparam int AW = $clog2(DBG_DEPTH);
  localparam int CW = AW + 1;
  logic [NUM_CH*LW-1:0] stage_q;
  logic                 logged;
  logic                 ovf;
  logic [31:0]          f_pc   [DBG_DEPTH];
  logic [4:0]           f_num  [DBG_DEPTH];
  logic [31:0]          f_data [DBG_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        cnt;
  logic [NUM_CH-1:0]    eff_we;
  logic [31:0]          lane_pc [NUM_CH];
  logic [4:0]           lane_wa [NUM_CH];
  logic [31:0]          lane_wd [NUM_CH];
  logic [AW-1:0]        slot    [NUM_CH];
  logic [CW-1:0]        push_cnt, free;
  logic                 pop, need, push, change;
  logic                 unused_stall;
  assign unused_stall = ^bus.stall;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    logic [LW-1:0] l;
    logic [31:0]   wd;
    logic [7:0]    b;
    logic [15:0]   h;
    assign l  = stage_q[g*LW +: LW];
    assign wd = l[37:6];
    assign b  = wd[8*l[1:0] +: 8];
    assign h  = wd[16*l[1] +: 16];
    assign eff_we[g]  = l[76] & l[43] & (l[42:38] != 5'd0);
    assign lane_pc[g] = l[75:44];
    assign lane_wa[g] = l[42:38];
    assign lane_wd[g] = !l[5] || l[4] ? wd :
                        l[3] ? (l[2] ? {16'b0, h} : {{16{h[15]}}, h}) :
                               (l[2] ? {24'b0, b} : {{24{b[7]}}, b});
    assign bus.wb_to_rf_bus[g*38 +: 38] = {eff_we[g], lane_wa[g], lane_wd[g]};
  end
  // each writing lane takes the next free slot after the lower lanes' writes
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      slot[i]  = wr_ptr + push_cnt[AW-1:0];
      push_cnt = push_cnt + CW'(eff_we[i]);
    end
  end
  assign pop    = cnt != '0;
  assign free   = CW'(DBG_DEPTH) - cnt + CW'(pop);
  assign need   = !logged && push_cnt != '0;
  assign push   = need && free >= push_cnt;
  assign change = bus.flush | ~bus.stall[STAGE_IDX] | ~bus.stall[STAGE_IDX+1];
  assign bus.stallreq_wb       = need && free < push_cnt;
  assign bus.dbg_overflow      = ovf;
  assign bus.debug_wb_pc       = pop ? f_pc[rd_ptr]   : '0;
  assign bus.debug_wb_rf_wen   = {4{pop}};
  assign bus.debug_wb_rf_wnum  = pop ? f_num[rd_ptr]  : '0;
  assign bus.debug_wb_rf_wdata = pop ? f_data[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      logged  <= 1'b0;
      ovf     <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
    end else begin
      stage_q <= bus.flush ? '0 : !bus.stall[STAGE_IDX] ? bus.mem_to_wb_bus :
                 !bus.stall[STAGE_IDX+1] ? '0 : stage_q;
      logged  <= !change && (logged || push);
      ovf     <= ovf || (change && need && !push);
      rd_ptr  <= rd_ptr + AW'(pop);
      wr_ptr  <= wr_ptr + (push ? push_cnt[AW-1:0] : '0);
      cnt     <= cnt + (push ? push_cnt : '0) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push && eff_we[i]) begin
        f_pc[slot[i]]   <= lane_pc[i];
        f_num[slot[i]]  <= lane_wa[i];
        f_data[slot[i]] <= lane_wd[i];
      end
    end
  end
endmodule

// File: tb/tb_wb_stage_mc.sv
// tb_wb_stage_mc: directed and randomized bench for wb_stage_mc against a queue-based reference model
module tb_wb_stage_mc;
  localparam int NC = 2;
  localparam int DEPTH = 8;
  localparam int S = 4;
  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        le;
    logic [2:0]  lt;
    logic [1:0]  lo;
  } lane_t;
  logic clk, rst;
  int checks = 0, failures = 0;
  logic [NC*77-1:0] m_reg;
  logic m_logged, m_ovf;
  logic [68:0] q[$];
  wb_stage_mc_if #(.NUM_CH(NC), .STALL_W(6)) bus();
  wb_stage_mc #(.NUM_CH(NC), .STALL_W(6), .STAGE_IDX(S), .DBG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  function automatic lane_t mk(input logic v, input logic [31:0] pc, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic le, input logic [2:0] lt, input logic [1:0] lo);
    lane_t l;
    l = '{v, pc, we, wa, wd, le, lt, lo};
    return l;
  endfunction
  function automatic lane_t ln(input logic [NC*77-1:0] b, input int i);
    return b[i*77 +: 77];
  endfunction
  function automatic logic [31:0] align(input logic [31:0] wd, input logic [2:0] lt, input logic [1:0] lo);
    int unsigned x;
    if (lt >= 3'd4) return wd;
    if (lt >= 3'd2) begin
      x = (wd / (32'd1 << (16 * lo[1]))) % 65536;
      if (lt == 3'd2 && x >= 32768) x = x + 32'hFFFF0000;
    end else begin
      x = (wd / (32'd1 << (8 * lo))) % 256;
      if (lt == 3'd0 && x >= 128) x = x + 32'hFFFFFF00;
    end
    return x;
  endfunction
  function automatic logic writes(input lane_t l);
    return l.v && l.we && l.wa != 5'd0;
  endfunction
  function automatic logic [31:0] data_of(input lane_t l);
    return l.le ? align(l.wd, l.lt, l.lo) : l.wd;
  endfunction
  function automatic int pcnt();
    int n = 0;
    for (int i = 0; i < NC; i++) if (writes(ln(m_reg, i))) n++;
    return n;
  endfunction
  function automatic logic m_req();
    int sz = q.size();
    return pcnt() > 0 && !m_logged && (DEPTH - sz + (sz > 0 ? 1 : 0)) < pcnt();
  endfunction
  function automatic logic [NC*38-1:0] exp_rf();
    logic [NC*38-1:0] r;
    lane_t l;
    for (int i = 0; i < NC; i++) begin
      l = ln(m_reg, i);
      r[i*38 +: 38] = {writes(l), l.wa, data_of(l)};
    end
    return r;
  endfunction
  task automatic model_step(input logic r, input logic f, input logic [5:0] st, input logic [NC*77-1:0] b);
    int n;
    logic pushnow, chg;
    lane_t l;
    n = pcnt();
    if (r) begin
      m_reg = '0; q.delete(); m_logged = 0; m_ovf = 0;
      return;
    end
    if (q.size() > 0) void'(q.pop_front());
    pushnow = !m_logged && n > 0 && (DEPTH - q.size()) >= n;
    if (pushnow)
      for (int i = 0; i < NC; i++) begin
        l = ln(m_reg, i);
        if (writes(l)) q.push_back({l.pc, l.wa, data_of(l)});
      end
    chg = f || !st[S] || !st[S+1];
    if (chg && !m_logged && n > 0 && !pushnow) m_ovf = 1;
    m_logged = !chg && (m_logged || pushnow);
    m_reg = f ? '0 : !st[S] ? b : !st[S+1] ? '0 : m_reg;
  endtask
  task automatic check_all();
    logic [68:0] h;
    h = q.size() > 0 ? q[0] : '0;
    chk("rf_bus", bus.wb_to_rf_bus, exp_rf());
    chk("stallreq", bus.stallreq_wb, m_req());
    chk("overflow", bus.dbg_overflow, m_ovf);
    chk("dbg_wen", bus.debug_wb_rf_wen, q.size() > 0 ? 4'hF : 4'h0);
    chk("dbg_pc", bus.debug_wb_pc, h[68:37]);
    chk("dbg_wnum", bus.debug_wb_rf_wnum, h[36:32]);
    chk("dbg_wdata", bus.debug_wb_rf_wdata, h[31:0]);
  endtask
  task automatic cyc(input logic r, input logic f, input logic [5:0] st, input logic [NC*77-1:0] b);
    rst = r; bus.flush = f; bus.stall = st; bus.mem_to_wb_bus = b;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step(r, f, st, b);
    #1;
  endtask
  task automatic go(input logic [NC*77-1:0] b);
    cyc(1'b0, 1'b0, m_req() ? 6'h30 : 6'h00, b);
  endtask
  function automatic lane_t rnd_lane();
    return mk($urandom % 4 != 0, $urandom, $urandom % 4 != 0, 5'($urandom % 8), $urandom,
              1'($urandom % 2), 3'($urandom % 8), 2'($urandom % 4));
  endfunction
  logic [NC*77-1:0] b, two;
  logic [2:0]  ld_t [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
  logic [1:0]  ld_o [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
  logic [31:0] ld_e [4] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01};
  initial begin
    rst = 1'b1; bus.flush = 1'b0; bus.stall = '0; bus.mem_to_wb_bus = '0;
    m_reg = '0; m_logged = 0; m_ovf = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc(1, 0, 0, '0);
    chk("reset_wen", bus.debug_wb_rf_wen, 4'h0);
    chk("reset_rf", bus.wb_to_rf_bus, '0);
    b = {77'b0, mk(1, 32'h100, 1, 5'd5, 32'h1234, 0, 0, 0)};
    cyc(0, 0, 0, b);
    chk("single_rf", bus.wb_to_rf_bus[37:0], {1'b1, 5'd5, 32'h1234});
    cyc(0, 0, 0, '0);
    chk("single_wnum", bus.debug_wb_rf_wnum, 5'd5);
    chk("single_wen", bus.debug_wb_rf_wen, 4'hF);
    cyc(0, 0, 0, '0);
    chk("single_drained", bus.debug_wb_rf_wen, 4'h0);
    b = {mk(1, 32'h204, 1, 5'd4, 32'hB, 0, 0, 0), mk(1, 32'h200, 1, 5'd3, 32'hA, 0, 0, 0)};
    cyc(0, 0, 0, b);
    cyc(0, 0, 0, '0);
    chk("dual_first", {bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata}, {5'd3, 32'hA});
    cyc(0, 0, 0, '0);
    chk("dual_second", {bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata}, {5'd4, 32'hB});
    b = {77'b0, mk(1, 32'h300, 1, 5'd0, 32'h55, 0, 0, 0)};
    cyc(0, 0, 0, b);
    chk("zero_reg_we", bus.wb_to_rf_bus[37], 1'b0);
    cyc(0, 0, 0, '0);
    chk("zero_reg_trace", bus.debug_wb_rf_wen, 4'h0);
    for (int i = 0; i < 4; i++) begin
      b = {77'b0, mk(1, 32'h400, 1, 5'd1, 32'h80FF7F01, 1, ld_t[i], ld_o[i])};
      cyc(0, 0, 0, b);
      chk($sformatf("load%0d", i), bus.wb_to_rf_bus[31:0], ld_e[i]);
    end
    repeat (3) cyc(0, 0, 0, '0);
    b = {77'b0, mk(1, 32'h500, 1, 5'd7, 32'h77, 0, 0, 0)};
    cyc(0, 0, 0, b);
    cyc(0, 0, 6'h10, {rnd_lane(), rnd_lane()});
    chk("bubble_we", bus.wb_to_rf_bus[37], 1'b0);
    repeat (3) cyc(0, 0, 0, '0);
    b = {77'b0, mk(1, 32'h600, 1, 5'd9, 32'h99, 0, 0, 0)};
    cyc(0, 0, 0, b);
    repeat (3) cyc(0, 0, 6'h30, {rnd_lane(), rnd_lane()});
    chk("hold_once", bus.debug_wb_rf_wen, 4'h0);
    chk("hold_kept", bus.wb_to_rf_bus[37:0], {1'b1, 5'd9, 32'h99});
    cyc(0, 0, 0, '0);
    two = {mk(1, 32'h704, 1, 5'd12, 32'hC, 0, 0, 0), mk(1, 32'h700, 1, 5'd11, 32'hB, 0, 0, 0)};
    repeat (3) go(two);
    cyc(0, 1, 0, two);
    chk("flush_rf", bus.wb_to_rf_bus, '0);
    chk("flush_drain", bus.debug_wb_rf_wen, 4'hF);
    repeat (10) cyc(0, 0, 0, '0);
    for (int i = 0; i < 20 && !m_req(); i++) go(two);
    chk("full_req", bus.stallreq_wb, 1'b1);
    go(two);
    chk("full_release", bus.stallreq_wb, 1'b0);
    repeat (12) go('0);
    for (int i = 0; i < 20 && !m_req(); i++) go(two);
    chk("ovf_setup", bus.stallreq_wb, 1'b1);
    cyc(0, 0, 0, b);
    chk("ovf_set", bus.dbg_overflow, 1'b1);
    repeat (3) cyc(0, 0, 0, '0);
    chk("ovf_sticky", bus.dbg_overflow, 1'b1);
    cyc(1, 0, 0, '0);
    chk("rst_wen", bus.debug_wb_rf_wen, 4'h0);
    chk("rst_ovf", bus.dbg_overflow, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic [5:0] st;
      st = m_req() && ($urandom % 10 != 0) ? 6'h30 : 6'(($urandom % 4) << 4);
      cyc($urandom % 100 == 0, $urandom % 25 == 0, st, {rnd_lane(), rnd_lane()});
    end
    repeat (10) cyc(0, 0, 0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
